dc_fu_dma_line_scheduler: RTL and testbench
===========================================

# dc_fu_dma_line_scheduler

Frame/line scheduler of the fetching unit DMA. On each frame start it walks the configured frame buffer line by line. Per line it waits for room in the downstream line FIFO, loads the burst count and pulses `start_fetch` into the DMA handshake manager, and supplies AXI read address and length for every burst that manager accepts (`next_addr`). It also collects AXI response errors and frame overrun status.

## Interface
- `ADDR_WIDTH`, 32, AXI address width
- `FETCH_WORD_COUNT_WIDTH`, 16, width of line word count
- `MAX_BURST_LEN`, 4, log2 of beats per full burst (16 beats)
- `WORD_BYTES_LOG2`, 3, log2 of bytes per AXI beat (64-bit bus)
- `LINE_COUNT_WIDTH`, 12, width of line counters
---
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `en` in 1 — clock enable; low freezes all state and outputs
- `frame_start` in 1 — one-cycle pulse, begin frame
- `cfg_base_addr` in ADDR_WIDTH — byte address of line 0
- `cfg_line_stride` in ADDR_WIDTH — byte offset between lines
- `cfg_line_words` in FETCH_WORD_COUNT_WIDTH — beats per line
- `cfg_line_count` in LINE_COUNT_WIDTH — lines per frame
- `fifo_space` in FETCH_WORD_COUNT_WIDTH — free words in line FIFO
- `next_addr` in 1 — burst address accepted (from handshake manager)
- `error_flag` in 2 — AXI rresp from handshake manager
- `start_fetch` out 1 — one-cycle pulse, start line
- `trans_count` out FETCH_WORD_COUNT_WIDTH-MAX_BURST_LEN — bursts remaining in line
- `axi_araddr` out ADDR_WIDTH — current burst address
- `axi_arlen` out 8 — current burst beats minus one
- `busy` out 1 — frame in progress
- `frame_done` out 1 — one-cycle pulse after last line issued
- `err_sticky` out 2 — OR of all nonzero rresp this frame
- `overrun` out 1 — sticky: frame_start arrived while busy

## Operation
- States: IDLE, WAIT_SPACE, START, RUN, LINE_END.
- IDLE, `frame_start`:
  - Latch all cfg inputs, clear `err_sticky` and `overrun`, set `line_idx`=0 and `line_addr`=`cfg_base_addr`, then go to WAIT_SPACE.
  - If `cfg_line_words`==0 or `cfg_line_count`==0, go straight to IDLE and pulse `frame_done` next cycle; no fetch is issued.
- WAIT_SPACE: when `fifo_space` ≥ latched line_words, go to START.
- START:
  - `start_fetch`=1.
  - `trans_count`=ceil(line_words / 2^MAX_BURST_LEN).
  - `axi_araddr`=`line_addr`.
  - `axi_arlen` is that burst's beats-1.
  - Go to RUN.
- RUN, on `next_addr`:
  - Decrement `trans_count` and add 2^(MAX_BURST_LEN+WORD_BYTES_LOG2) to `axi_araddr`.
  - Update `axi_arlen`: the final burst carries line_words mod 2^MAX_BURST_LEN beats; a full burst is used if that remainder is 0.
  - When the decrement reaches 0, go to LINE_END.
- LINE_END:
  - Increment `line_idx`.
  - If the incremented value equals `line_count`, pulse `frame_done` and go to IDLE.
  - Otherwise `line_addr` += stride (mod 2^ADDR_WIDTH) and go to WAIT_SPACE.
- `next_addr` outside RUN is ignored.
- `error_flag`: OR into `err_sticky` on every cycle where `busy`=1. Errors do not abort the frame.
- `frame_start` while `busy`: ignored, sets `overrun`.
- Address arithmetic wraps silently at ADDR_WIDTH.
- The word-count to burst-count conversion is a ceiling divide.

## Timing
- Reset values: state IDLE; all outputs 0; internal counters 0.
- All outputs are registered.
- `frame_start` to first `start_fetch`: minimum 2 cycles (IDLE→WAIT_SPACE→START).
- `trans_count`, `axi_araddr` and `axi_arlen` are valid in the `start_fetch` cycle and stay stable until the next `next_addr` edge. The new values are visible the cycle after `next_addr`.
- `trans_count` reads 0 from the cycle after the last `next_addr`; the handshake manager returns to idle on it.
- Minimum 2 cycles between consecutive `start_fetch` pulses (LINE_END, WAIT_SPACE).
- `busy`=1 from the cycle after `frame_start` acceptance through the `frame_done` cycle.
- `rst` mid-frame: immediate return to IDLE and all outputs 0; no `frame_done`.
- `en`=0 holds the current state. Inputs sampled during `en`=0 have no effect, including a `next_addr` pulse.

## Structure
- Shared package `dc_fu_dma_pkg`:
  - state enum
  - AXI rresp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - BURST_BEATS / BURST_BYTES localparams derived from the parameters
- Sub-module `dc_fu_dma_burst_calc`: registered ceiling divide and last-burst length from line_words. Its output is computed during WAIT_SPACE.

## Test plan
- Basic line: words=40, lines=1, base=0x1000, space=64, frame_start → `trans_count`=3; arlen 15,15,7; araddr 0x1000, 0x1080, 0x1100; `frame_done` after the third `next_addr`.
- Stride: words=16, lines=3, stride=0x800 → 3 `start_fetch` pulses at 0x1000, 0x1800, 0x2000; arlen 15 each; one `frame_done`.
- Backpressure: `fifo_space`=10 < words=16 → no `start_fetch` until space=16; `start_fetch` follows within 1 cycle.
- Degenerate: `cfg_line_words`=0 → no `start_fetch`, `frame_done` 2 cycles after frame_start; `busy` pulses.
- Errors and overrun: `error_flag`=2 mid-frame plus a second `frame_start` while busy → `err_sticky`=2 and `overrun`=1 held to frame end; both cleared by the next accepted frame_start.
- Reset/enable: assert `rst` in RUN → all outputs 0 immediately. Separately, `en`=0 during RUN with a `next_addr` pulse → `trans_count` unchanged.

Source files
------------

// File: rtl/dc_fu_dma_pkg.sv
// Shared definitions for the fetching-unit DMA line scheduler.
//   - scheduler state encoding
//   - AXI rresp codes
//   - default burst geometry and the beat/byte sizes derived from it
package dc_fu_dma_pkg;

  localparam int MAX_BURST_LEN_DEF   = 4;  // log2 beats per full burst
  localparam int WORD_BYTES_LOG2_DEF = 3;  // log2 bytes per AXI beat

  localparam int BURST_BEATS = 1 << MAX_BURST_LEN_DEF;
  localparam int BURST_BYTES = BURST_BEATS << WORD_BYTES_LOG2_DEF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_START      = 3'd2,
    ST_RUN        = 3'd3,
    ST_LINE_END   = 3'd4
  } state_e;

  localparam logic [1:0] RRESP_OKAY   = 2'd0;
  localparam logic [1:0] RRESP_EXOKAY = 2'd1;
  localparam logic [1:0] RRESP_SLVERR = 2'd2;
  localparam logic [1:0] RRESP_DECERR = 2'd3;

endpackage

// File: rtl/dc_fu_dma_line_scheduler_if.sv
// Handshake between the line scheduler and the DMA handshake manager.
//   start_fetch  : scheduler -> manager, one-cycle line start pulse
//   trans_count  : scheduler -> manager, bursts remaining in the line
//   axi_araddr   : scheduler -> manager, current burst address
//   axi_arlen    : scheduler -> manager, current burst beats minus one
//   next_addr    : manager -> scheduler, current burst address accepted
//   error_flag   : manager -> scheduler, AXI rresp
interface dc_fu_dma_line_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TC_WIDTH   = 12
);
  logic                  start_fetch;
  logic [TC_WIDTH-1:0]   trans_count;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic                  next_addr;
  logic [1:0]            error_flag;

  modport master (
    output start_fetch, trans_count, axi_araddr, axi_arlen,
    input  next_addr, error_flag
  );

  modport slave (
    input  start_fetch, trans_count, axi_araddr, axi_arlen,
    output next_addr, error_flag
  );
endinterface

// File: rtl/dc_fu_dma_burst_calc.sv
// Burst geometry of one line: registered ceiling divide of the line word
// count by the burst size, and the beats-minus-one of the final burst.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : clock enable
//   i_load          : capture i_words (frame accepted)
//   i_words         : beats per line
//   o_bursts        : ceil(i_words / 2^MAX_BURST_LEN)
//   o_last_len_m1   : beats-1 of the final burst (full burst if remainder 0)
// A line word count above (2^TC_W - 1) * 2^MAX_BURST_LEN wraps o_bursts.
module dc_fu_dma_burst_calc
  import dc_fu_dma_pkg::*;
#(
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int MAX_BURST_LEN          = MAX_BURST_LEN_DEF
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            en,
  input  logic                                            i_load,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0]               i_words,
  output logic [FETCH_WORD_COUNT_WIDTH-MAX_BURST_LEN-1:0] o_bursts,
  output logic [7:0]                                      o_last_len_m1
);
  localparam int TC_W = FETCH_WORD_COUNT_WIDTH - MAX_BURST_LEN;
  localparam logic [7:0] FULL_LEN_M1 = 8'((1 << MAX_BURST_LEN) - 1);

  logic [TC_W-1:0]          w_full;
  logic [MAX_BURST_LEN-1:0] w_rem;
  logic [TC_W-1:0]          r_bursts;
  logic [7:0]               r_last_len_m1;

  assign w_full = i_words[FETCH_WORD_COUNT_WIDTH-1:MAX_BURST_LEN];
  assign w_rem  = i_words[MAX_BURST_LEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bursts      <= '0;
      r_last_len_m1 <= '0;
    end else if (en && i_load) begin
      // a partial final burst adds one to the full-burst count
      r_bursts      <= w_full + TC_W'(|w_rem);
      r_last_len_m1 <= (w_rem == '0) ? FULL_LEN_M1 : 8'(w_rem) - 8'd1;
    end
  end

  assign o_bursts      = r_bursts;
  assign o_last_len_m1 = r_last_len_m1;
endmodule

// File: rtl/dc_fu_dma_line_scheduler.sv
// Frame/line scheduler of the fetching-unit DMA. On frame_start it walks
// the configured frame buffer line by line, waits for FIFO room per line,
// pulses start_fetch and presents the address/length of every burst the
// handshake manager accepts. Collects rresp errors and frame overruns.
//   clk, rst         : clock, asynchronous active-high reset
//   en               : clock enable, low freezes everything
//   frame_start      : begin frame (ignored and flagged while busy)
//   cfg_*            : frame geometry, latched on frame acceptance
//   fifo_space       : free words in downstream line FIFO
//   hs               : handshake manager interface (master side)
//   busy             : frame in progress, through the frame_done cycle
//   frame_done       : one-cycle pulse after the last line is issued
//   err_sticky       : OR of rresp seen while busy
//   overrun          : frame_start arrived while busy
module dc_fu_dma_line_scheduler
  import dc_fu_dma_pkg::*;
#(
  parameter int ADDR_WIDTH             = 32,
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int MAX_BURST_LEN          = MAX_BURST_LEN_DEF,
  parameter int WORD_BYTES_LOG2        = WORD_BYTES_LOG2_DEF,
  parameter int LINE_COUNT_WIDTH       = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              frame_start,
  input  logic [ADDR_WIDTH-1:0]             cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]             cfg_line_stride,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0] cfg_line_words,
  input  logic [LINE_COUNT_WIDTH-1:0]       cfg_line_count,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0] fifo_space,
  dc_fu_dma_line_scheduler_if.master        hs,
  output logic                              busy,
  output logic                              frame_done,
  output logic [1:0]                        err_sticky,
  output logic                              overrun
);
  localparam int TC_W = FETCH_WORD_COUNT_WIDTH - MAX_BURST_LEN;
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP =
    ADDR_WIDTH'(1 << (MAX_BURST_LEN + WORD_BYTES_LOG2));
  localparam logic [7:0] FULL_LEN_M1 = 8'((1 << MAX_BURST_LEN) - 1);

  localparam logic [2:0] S_IDLE       = ST_IDLE;
  localparam logic [2:0] S_WAIT_SPACE = ST_WAIT_SPACE;
  localparam logic [2:0] S_START      = ST_START;
  localparam logic [2:0] S_RUN        = ST_RUN;
  localparam logic [2:0] S_LINE_END   = ST_LINE_END;

  logic [2:0]                        r_state;
  logic [FETCH_WORD_COUNT_WIDTH-1:0] r_words;
  logic [LINE_COUNT_WIDTH-1:0]       r_line_count;
  logic [LINE_COUNT_WIDTH-1:0]       r_line_idx;
  logic [ADDR_WIDTH-1:0]             r_stride;
  logic [ADDR_WIDTH-1:0]             r_line_addr;
  logic                              r_start_fetch;
  logic [TC_W-1:0]                   r_trans_count;
  logic [ADDR_WIDTH-1:0]             r_araddr;
  logic [7:0]                        r_arlen;
  logic                              r_busy;
  logic                              r_frame_done;
  logic                              r_done_pend;
  logic [1:0]                        r_err;
  logic                              r_overrun;

  logic                              w_accept;
  logic [TC_W-1:0]                   w_bursts;
  logic [7:0]                        w_last_m1;
  logic [TC_W-1:0]                   w_tc_dec;
  logic [LINE_COUNT_WIDTH-1:0]       w_idx_inc;

  // busy also covers the frame_done cycle, so a frame can only be accepted
  // once the previous one is fully retired
  assign w_accept  = (r_state == S_IDLE) && !r_busy && frame_start;
  assign w_tc_dec  = r_trans_count - TC_W'(1);
  assign w_idx_inc = r_line_idx + LINE_COUNT_WIDTH'(1);

  dc_fu_dma_burst_calc #(
    .FETCH_WORD_COUNT_WIDTH(FETCH_WORD_COUNT_WIDTH),
    .MAX_BURST_LEN         (MAX_BURST_LEN)
  ) u_burst_calc (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i_load       (w_accept),
    .i_words      (cfg_line_words),
    .o_bursts     (w_bursts),
    .o_last_len_m1(w_last_m1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_words       <= '0;
      r_line_count  <= '0;
      r_line_idx    <= '0;
      r_stride      <= '0;
      r_line_addr   <= '0;
      r_start_fetch <= 1'b0;
      r_trans_count <= '0;
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_done_pend   <= 1'b0;
      r_err         <= '0;
      r_overrun     <= 1'b0;
    end else if (en) begin
      if (r_busy) begin
        r_err <= r_err | hs.error_flag;
      end
      if (frame_start && r_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_frame_done) begin
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_done_pend) begin
            // empty frame: retire one cycle after acceptance
            r_frame_done <= 1'b1;
            r_done_pend  <= 1'b0;
          end else if (w_accept) begin
            r_words      <= cfg_line_words;
            r_line_count <= cfg_line_count;
            r_stride     <= cfg_line_stride;
            r_line_addr  <= cfg_base_addr;
            r_line_idx   <= '0;
            r_err        <= '0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b1;
            if (cfg_line_words == '0 || cfg_line_count == '0) begin
              r_done_pend <= 1'b1;
            end else begin
              r_state <= S_WAIT_SPACE;
            end
          end
        end

        S_WAIT_SPACE: begin
          if (fifo_space >= r_words) begin
            r_start_fetch <= 1'b1;
            r_trans_count <= w_bursts;
            r_araddr      <= r_line_addr;
            r_arlen       <= (w_bursts == TC_W'(1)) ? w_last_m1 : FULL_LEN_M1;
            r_state       <= S_START;
          end
        end

        S_START: begin
          r_start_fetch <= 1'b0;
          r_state       <= S_RUN;
        end

        S_RUN: begin
          if (hs.next_addr) begin
            r_trans_count <= w_tc_dec;
            r_araddr      <= r_araddr + BURST_STEP;
            // only the final burst may be short
            r_arlen       <= (w_tc_dec == TC_W'(1)) ? w_last_m1 : FULL_LEN_M1;
            if (w_tc_dec == '0) begin
              r_state <= S_LINE_END;
            end
          end
        end

        S_LINE_END: begin
          r_line_idx <= w_idx_inc;
          if (w_idx_inc == r_line_count) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_line_addr <= r_line_addr + r_stride;
            r_state     <= S_WAIT_SPACE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hs.start_fetch = r_start_fetch;
  assign hs.trans_count = r_trans_count;
  assign hs.axi_araddr  = r_araddr;
  assign hs.axi_arlen   = r_arlen;
  assign busy           = r_busy;
  assign frame_done     = r_frame_done;
  assign err_sticky     = r_err;
  assign overrun        = r_overrun;
endmodule

// File: tb/tb_dc_fu_dma_line_scheduler.sv
module tb_dc_fu_dma_line_scheduler;
  import dc_fu_dma_pkg::*;

  localparam int AW  = 32;
  localparam int WW  = 16;
  localparam int LW  = 12;
  localparam int TCW = WW - MAX_BURST_LEN_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          frame_start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_line_stride;
  logic [WW-1:0] cfg_line_words;
  logic [LW-1:0] cfg_line_count;
  logic [WW-1:0] fifo_space;
  logic          busy;
  logic          frame_done;
  logic [1:0]    err_sticky;
  logic          overrun;

  dc_fu_dma_line_scheduler_if #(.ADDR_WIDTH(AW), .TC_WIDTH(TCW)) hs ();

  dc_fu_dma_line_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .frame_start    (frame_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_line_stride(cfg_line_stride),
    .cfg_line_words (cfg_line_words),
    .cfg_line_count (cfg_line_count),
    .fifo_space     (fifo_space),
    .hs             (hs.master),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_sticky     (err_sticky),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sf     = 0;

  // reference frame description
  logic [AW-1:0] m_base;
  logic [AW-1:0] m_stride;
  int            m_words;
  int            m_lines;
  logic [1:0]    m_err;
  logic          m_ovr;
  bit            m_err_en;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nb_of(input int w);
    return (w + BURST_BEATS - 1) / BURST_BEATS;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int l, input int b);
    return m_base + m_stride * 32'(l) + 32'(b * BURST_BYTES);
  endfunction

  function automatic int exp_len(input int b);
    int rem;
    rem = m_words % BURST_BEATS;
    if (b == nb_of(m_words) - 1 && rem != 0) return rem - 1;
    return BURST_BEATS - 1;
  endfunction

  task automatic drive_err();
    logic [1:0] e;
    e = 2'd0;
    if (m_err_en && $urandom_range(0, 3) == 0) e = 2'($urandom_range(1, 3));
    hs.error_flag = e;
    m_err = m_err | e;
  endtask

  task automatic check_burst(input int l, input int b);
    chk("trans_count", 64'(hs.trans_count), 64'(nb_of(m_words) - b));
    chk("axi_araddr", 64'(hs.axi_araddr), 64'(exp_addr(l, b)));
    chk("axi_arlen", 64'(hs.axi_arlen), 64'(exp_len(b)));
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input int words, input int lines);
    cfg_base_addr   = base;
    cfg_line_stride = stride;
    cfg_line_words  = WW'(words);
    cfg_line_count  = LW'(lines);
    frame_start     = 1'b1;
    tick();
    frame_start     = 1'b0;
    // configuration must have been captured at acceptance
    cfg_base_addr   = $urandom;
    cfg_line_stride = $urandom;
    cfg_line_words  = WW'($urandom_range(1, 200));
    cfg_line_count  = LW'($urandom_range(1, 9));
    m_base = base; m_stride = stride; m_words = words; m_lines = lines;
    m_err = 2'd0; m_ovr = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("err_cleared", 64'(err_sticky), 64'd0);
    chk("ovr_cleared", 64'(overrun), 64'd0);
  endtask

  task automatic wait_start(input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (hs.start_fetch !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cycles));
    if (hs.start_fetch === 1'b1) n_sf++;
  endtask

  // accept every burst of line l with random gaps; ends in the cycle after
  // the final next_addr
  task automatic pulse_bursts(input int l);
    int nb;
    int gap;
    nb = nb_of(m_words);
    for (int b = 0; b < nb; b++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive_err();
        tick();
        chk("hold_trans_count", 64'(hs.trans_count), 64'(nb - b));
      end
      hs.next_addr = 1'b1;
      drive_err();
      tick();
      hs.next_addr  = 1'b0;
      hs.error_flag = 2'd0;
      if (b + 1 < nb) check_burst(l, b + 1);
      else chk("trans_count_zero", 64'(hs.trans_count), 64'd0);
    end
  endtask

  task automatic finish_frame();
    tick();
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd1);
    chk("err_sticky_end", 64'(err_sticky), 64'(m_err));
    chk("overrun_end", 64'(overrun), 64'(m_ovr));
    tick();
    chk("frame_done_low", 64'(frame_done), 64'd0);
    chk("busy_low", 64'(busy), 64'd0);
    chk("err_sticky_held", 64'(err_sticky), 64'(m_err));
    chk("overrun_held", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic do_frame(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input int words, input int lines, input bit errs, input int ovr_line);
    start_frame(base, stride, words, lines);
    m_err_en = errs;
    for (int l = 0; l < lines; l++) begin
      if (l == 0) wait_start(1, "sf_latency_first");
      else wait_start(2, "sf_latency_next");
      check_burst(l, 0);
      tick();
      chk("sf_one_cycle", 64'(hs.start_fetch), 64'd0);
      if (l == ovr_line) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_ovr = 1'b1;
        chk("overrun_set", 64'(overrun), 64'd1);
      end
      pulse_bursts(l);
    end
    m_err_en = 1'b0;
    finish_frame();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sf0;
    bit seen;
    rst = 1'b1; en = 1'b1; frame_start = 1'b0;
    cfg_base_addr = '0; cfg_line_stride = '0; cfg_line_words = '0; cfg_line_count = '0;
    fifo_space = 16'hFFFF; hs.next_addr = 1'b0; hs.error_flag = 2'd0;
    m_err_en = 1'b0;
    repeat (3) tick();
    chk("rst_start_fetch", 64'(hs.start_fetch), 64'd0);
    chk("rst_trans_count", 64'(hs.trans_count), 64'd0);
    chk("rst_araddr", 64'(hs.axi_araddr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    rst = 1'b0;
    tick();

    // basic line: 40 words -> 3 bursts, 15/15/7 at 0x1000/0x1080/0x1100
    do_frame(32'h1000, 32'h0, 40, 1, 1'b0, -1);

    // stride over three full-burst lines
    sf0 = n_sf;
    do_frame(32'h1000, 32'h800, 16, 3, 1'b0, -1);
    chk("stride_sf_pulses", 64'(n_sf - sf0), 64'd3);

    // address wrap at 2^32
    do_frame(32'hFFFF_FF80, 32'h100, 40, 2, 1'b0, -1);

    // backpressure: no start until the FIFO can hold the line
    fifo_space = 16'd10;
    start_frame(32'h2000, 32'h0, 16, 1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (hs.start_fetch === 1'b1) seen = 1'b1;
      tick();
    end
    chk("bp_no_start", 64'(seen), 64'd0);
    fifo_space = 16'd16;
    wait_start(1, "bp_latency");
    check_burst(0, 0);
    tick();
    pulse_bursts(0);
    finish_frame();
    fifo_space = 16'hFFFF;

    // degenerate frames: zero words, then zero lines
    for (int k = 0; k < 2; k++) begin
      start_frame(32'h3000, 32'h40, (k == 0) ? 0 : 20, (k == 0) ? 4 : 0);
      chk("degen_done_early", 64'(frame_done), 64'd0);
      tick();
      chk("degen_done", 64'(frame_done), 64'd1);
      chk("degen_busy", 64'(busy), 64'd1);
      chk("degen_no_start", 64'(hs.start_fetch), 64'd0);
      tick();
      chk("degen_done_low", 64'(frame_done), 64'd0);
      chk("degen_busy_low", 64'(busy), 64'd0);
    end

    // error plus overrun in one frame, then cleared by the next frame
    m_err = 2'd0;
    start_frame(32'h4000, 32'h200, 24, 2);
    wait_start(1, "eo_latency");
    check_burst(0, 0);
    tick();
    hs.error_flag = RRESP_SLVERR;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    hs.error_flag = 2'd0;
    m_err = RRESP_SLVERR;
    m_ovr = 1'b1;
    chk("eo_err_now", 64'(err_sticky), 64'(RRESP_SLVERR));
    chk("eo_ovr_now", 64'(overrun), 64'd1);
    pulse_bursts(0);
    wait_start(2, "eo_latency_next");
    tick();
    pulse_bursts(1);
    finish_frame();
    do_frame(32'h5000, 32'h0, 8, 1, 1'b0, -1);

    // clock enable low during RUN swallows next_addr
    start_frame(32'h6000, 32'h0, 40, 1);
    wait_start(1, "en_latency");
    tick();
    en = 1'b0;
    hs.next_addr = 1'b1;
    tick();
    hs.next_addr = 1'b0;
    tick();
    en = 1'b1;
    check_burst(0, 0);
    pulse_bursts(0);
    finish_frame();

    // asynchronous reset in RUN
    start_frame(32'h7000, 32'h100, 40, 2);
    wait_start(1, "rst_latency");
    tick();
    hs.error_flag = RRESP_DECERR;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    hs.error_flag = 2'd0;
    hs.next_addr = 1'b1;
    tick();
    hs.next_addr = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstrun_start_fetch", 64'(hs.start_fetch), 64'd0);
    chk("rstrun_trans_count", 64'(hs.trans_count), 64'd0);
    chk("rstrun_araddr", 64'(hs.axi_araddr), 64'd0);
    chk("rstrun_arlen", 64'(hs.axi_arlen), 64'd0);
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_err", 64'(err_sticky), 64'd0);
    chk("rstrun_ovr", 64'(overrun), 64'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done === 1'b1 || busy === 1'b1 || hs.start_fetch === 1'b1) seen = 1'b1;
    end
    chk("rstrun_quiet", 64'(seen), 64'd0);

    // randomized frames against the reference model
    for (int r = 0; r < 12; r++) begin
      logic [AW-1:0] b;
      logic [AW-1:0] s;
      b = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_F000 + 32'($urandom_range(0, 4095)) : 32'($urandom_range(0, 8192));
      do_frame(b, s, $urandom_range(1, 80), $urandom_range(1, 3), 1'b1,
               ($urandom_range(0, 2) == 0) ? 0 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
